// File: rtl/zigzag_reorder.sv
// zigzag_reorder: reorders 8x8 blocks of DCT coefficients from row-major order to JPEG zigzag order.
// Latency: a block's first sample reaches o_data at the edge after the one that wrote its 64th input.
// Backpressure: ping-pong banks; i_ack drops only while both banks hold unread blocks; o_ack low freezes the output.
module zigzag_reorder #(
  parameter int width = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] i_data,
  input  logic             i_stb,
  output logic             i_ack,
  output logic [width-1:0] o_data,
  output logic             o_stb,
  input  logic             o_ack,
  output logic             o_last
);

  // Zigzag position k -> row-major index within the 8x8 block.
  function automatic logic [5:0] zz(input logic [5:0] k);
    logic [5:0] idx;
    case (k)
      6'd0:  idx = 6'd0;
      6'd1:  idx = 6'd1;
      6'd2:  idx = 6'd8;
      6'd3:  idx = 6'd16;
      6'd4:  idx = 6'd9;
      6'd5:  idx = 6'd2;
      6'd6:  idx = 6'd3;
      6'd7:  idx = 6'd10;
      6'd8:  idx = 6'd17;
      6'd9:  idx = 6'd24;
      6'd10: idx = 6'd32;
      6'd11: idx = 6'd25;
      6'd12: idx = 6'd18;
      6'd13: idx = 6'd11;
      6'd14: idx = 6'd4;
      6'd15: idx = 6'd5;
      6'd16: idx = 6'd12;
      6'd17: idx = 6'd19;
      6'd18: idx = 6'd26;
      6'd19: idx = 6'd33;
      6'd20: idx = 6'd40;
      6'd21: idx = 6'd48;
      6'd22: idx = 6'd41;
      6'd23: idx = 6'd34;
      6'd24: idx = 6'd27;
      6'd25: idx = 6'd20;
      6'd26: idx = 6'd13;
      6'd27: idx = 6'd6;
      6'd28: idx = 6'd7;
      6'd29: idx = 6'd14;
      6'd30: idx = 6'd21;
      6'd31: idx = 6'd28;
      6'd32: idx = 6'd35;
      6'd33: idx = 6'd42;
      6'd34: idx = 6'd49;
      6'd35: idx = 6'd56;
      6'd36: idx = 6'd57;
      6'd37: idx = 6'd50;
      6'd38: idx = 6'd43;
      6'd39: idx = 6'd36;
      6'd40: idx = 6'd29;
      6'd41: idx = 6'd22;
      6'd42: idx = 6'd15;
      6'd43: idx = 6'd23;
      6'd44: idx = 6'd30;
      6'd45: idx = 6'd37;
      6'd46: idx = 6'd44;
      6'd47: idx = 6'd51;
      6'd48: idx = 6'd58;
      6'd49: idx = 6'd59;
      6'd50: idx = 6'd52;
      6'd51: idx = 6'd45;
      6'd52: idx = 6'd38;
      6'd53: idx = 6'd31;
      6'd54: idx = 6'd39;
      6'd55: idx = 6'd46;
      6'd56: idx = 6'd53;
      6'd57: idx = 6'd60;
      6'd58: idx = 6'd61;
      6'd59: idx = 6'd54;
      6'd60: idx = 6'd47;
      6'd61: idx = 6'd55;
      6'd62: idx = 6'd62;
      default: idx = 6'd63;
    endcase
    return idx;
  endfunction

  // Both banks share one array; the top address bit selects the bank.
  logic [width-1:0] mem_q [0:127];

  logic             w_bank_q, w_bank_d;
  logic [5:0]       w_cnt_q,  w_cnt_d;
  logic             r_bank_q, r_bank_d;
  logic [5:0]       r_cnt_q,  r_cnt_d;
  logic [1:0]       full_q,   full_d;
  logic [width-1:0] o_data_q, o_data_d;
  logic             o_stb_q,  o_stb_d;
  logic             o_last_q, o_last_d;
  logic             s_read;
  logic [width-1:0] rd_dat;

  assign i_ack  = i_stb & ~full_q[w_bank_q];
  // The output register is refilled whenever it is empty or being consumed, so there is no bubble.
  assign s_read = full_q[r_bank_q] & (~o_stb_q | o_ack);
  assign rd_dat = mem_q[{r_bank_q, zz(r_cnt_q)}];

  assign o_data = o_data_q;
  assign o_stb  = o_stb_q;
  assign o_last = o_last_q;

  // Next-state for the write/read pointers, bank flags and output register.
  always_comb begin
    w_bank_d = w_bank_q;
    w_cnt_d  = w_cnt_q;
    r_bank_d = r_bank_q;
    r_cnt_d  = r_cnt_q;
    full_d   = full_q;
    o_data_d = o_data_q;
    o_stb_d  = o_stb_q;
    o_last_d = o_last_q;

    if (i_ack) begin
      w_cnt_d = w_cnt_q + 6'd1;
      if (w_cnt_q == 6'd63) begin
        full_d[w_bank_q] = 1'b1;
        w_bank_d         = ~w_bank_q;
      end
    end

    // Set and clear never collide: set needs the bank empty, clear needs it full.
    if (s_read) begin
      r_cnt_d  = r_cnt_q + 6'd1;
      o_data_d = rd_dat;
      o_stb_d  = 1'b1;
      o_last_d = (r_cnt_q == 6'd63);
      if (r_cnt_q == 6'd63) begin
        full_d[r_bank_q] = 1'b0;
        r_bank_d         = ~r_bank_q;
      end
    end else if (o_ack) begin
      o_stb_d  = 1'b0;
      o_last_d = 1'b0;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (i_ack) begin
      mem_q[{w_bank_q, w_cnt_q}] <= i_data;
    end
  end

  // Control state and output register; reset drops every buffered block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_bank_q <= 1'b0;
      w_cnt_q  <= 6'd0;
      r_bank_q <= 1'b0;
      r_cnt_q  <= 6'd0;
      full_q   <= 2'b00;
      o_data_q <= '0;
      o_stb_q  <= 1'b0;
      o_last_q <= 1'b0;
    end else begin
      w_bank_q <= w_bank_d;
      w_cnt_q  <= w_cnt_d;
      r_bank_q <= r_bank_d;
      r_cnt_q  <= r_cnt_d;
      full_q   <= full_d;
      o_data_q <= o_data_d;
      o_stb_q  <= o_stb_d;
      o_last_q <= o_last_d;
    end
  end

endmodule
